decoder_top_sequencer: RTL and testbench

Top-level control slice of the hardware image decompressor.
- Detects a UART transfer request and waits for the UART-to-SRAM load to go quiet (1 s timeout).
- Then starts the decode milestones in order: M2 (which contains M3 entropy decode), then M1 (upsampling and colour-space conversion).
- Owns the single SRAM port mux, exposes top_state, and returns to S_IDLE when decoding is complete.

---
 rtl/decoder_pkg.sv | 31 +++
 rtl/decoder_top_sequencer_if.sv | 28 ++
 rtl/decoder_top_sequencer_sram_port_mux.sv | 56 +++++
 rtl/decoder_top_sequencer.sv | 155 +++++++++++++++
 tb/tb_decoder_top_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decoder_pkg.sv
// ----------------------------------------------------------------------------
// decoder_pkg
// Shared definitions for the image decompressor control slice. It holds the
// top-level state encoding, the SRAM memory map and the UART quiet-line
// timeout.
// ----------------------------------------------------------------------------
package decoder_pkg;

    typedef enum logic [2:0] {
        S_IDLE           = 3'd0,
        S_ENABLE_UART_RX = 3'd1,
        S_WAIT_UART_RX   = 3'd2,
        S_M2             = 3'd3,
        S_M1             = 3'd4
    } top_state_t;

    localparam int SRAM_AW      = 20;
    localparam int SRAM_DW      = 16;
    localparam int UART_TIMER_W = 26;

    // 1 s at 50 MHz; fits in UART_TIMER_W bits, so the counter never wraps
    localparam int unsigned UART_TIMEOUT = 32'd49999999;

    // SRAM memory map (word addresses)
    localparam int unsigned Y_BASE_ADDRESS          = 32'd0;
    localparam int unsigned U_BASE_ADDRESS          = 32'd38400;
    localparam int unsigned V_BASE_ADDRESS          = 32'd57600;
    localparam int unsigned COMPRESSED_BASE_ADDRESS = 32'd76800;
    localparam int unsigned RGB_BASE_ADDRESS        = 32'd146944;

endpackage

// File: rtl/decoder_top_sequencer_if.sv
// ----------------------------------------------------------------------------
// decoder_top_sequencer_if
// The single external SRAM port driven by the sequencer.
//   SRAM_address     : word address
//   SRAM_write_data  : write data
//   SRAM_we_n        : active-low write enable
// master: the sequencer (drives the pins); slave: the SRAM model/pad ring.
// ----------------------------------------------------------------------------
interface decoder_top_sequencer_if;
    import decoder_pkg::*;

    logic [SRAM_AW-1:0] SRAM_address;
    logic [SRAM_DW-1:0] SRAM_write_data;
    logic               SRAM_we_n;

    modport master (
        output SRAM_address,
        output SRAM_write_data,
        output SRAM_we_n
    );

    modport slave (
        input SRAM_address,
        input SRAM_write_data,
        input SRAM_we_n
    );

endinterface

// File: rtl/decoder_top_sequencer_sram_port_mux.sv
// ----------------------------------------------------------------------------
// sram_port_mux
// Purely combinational selector for the single SRAM port. The selection is
// taken from the registered top_state, so a sub-unit reaches the SRAM pins
// with no added latency.
//   top_state                 : current sequencer state (select)
//   vga_* / uart_* / m1_* / m2_* : candidate address/data/we_n sources
//   sram_address/_write_data/_we_n : selected port values
// ----------------------------------------------------------------------------
module sram_port_mux
    import decoder_pkg::*;
(
    input  top_state_t         top_state,
    input  logic [SRAM_AW-1:0] vga_sram_address,
    input  logic [SRAM_AW-1:0] uart_sram_address,
    input  logic [SRAM_DW-1:0] uart_sram_write_data,
    input  logic               uart_sram_we_n,
    input  logic [SRAM_AW-1:0] m2_sram_address,
    input  logic [SRAM_DW-1:0] m2_sram_write_data,
    input  logic               m2_sram_we_n,
    input  logic [SRAM_AW-1:0] m1_sram_address,
    input  logic [SRAM_DW-1:0] m1_sram_write_data,
    input  logic               m1_sram_we_n,
    output logic [SRAM_AW-1:0] sram_address,
    output logic [SRAM_DW-1:0] sram_write_data,
    output logic               sram_we_n
);

    always_comb begin
        // VGA reader is the read-only default owner of the port
        sram_address    = vga_sram_address;
        sram_write_data = '0;
        sram_we_n       = 1'b1;
        unique case (top_state)
            // the UART writer owns the port from the cycle it is enabled
            S_ENABLE_UART_RX,
            S_WAIT_UART_RX: begin
                sram_address    = uart_sram_address;
                sram_write_data = uart_sram_write_data;
                sram_we_n       = uart_sram_we_n;
            end
            S_M2: begin
                sram_address    = m2_sram_address;
                sram_write_data = m2_sram_write_data;
                sram_we_n       = m2_sram_we_n;
            end
            S_M1: begin
                sram_address    = m1_sram_address;
                sram_write_data = m1_sram_write_data;
                sram_we_n       = m1_sram_we_n;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decoder_top_sequencer.sv
// ----------------------------------------------------------------------------
// decoder_top_sequencer
// Top-level control of the image decompressor. A falling edge on the UART
// line starts a UART-to-SRAM load; once the line has been quiet for
// UART_TIMEOUT cycles, milestone M2 (with M3 inside) is started, then M1.
// When M1 finishes the sequencer returns to idle and the VGA reader owns SRAM.
//   CLOCK_50_I, resetn          : clock, synchronous active-low reset
//   UART_RX_I                   : raw serial line (falling-edge detect only)
//   uart_rx_enable              : enables the UART SRAM writer
//   uart_byte_received          : one pulse per received byte
//   uart_/m2_/m1_/vga_sram_*    : per-unit SRAM requests
//   m2_start/m2_done, m1_start/m1_done : one-cycle milestone handshakes
//   sram_bus                    : muxed SRAM port
//   top_state, UART_timer       : state and quiet-line counter
//   VGA_base_address            : first word of the RGB frame
// ----------------------------------------------------------------------------
module decoder_top_sequencer
    import decoder_pkg::*;
#(
    parameter int unsigned UART_TIMEOUT_P   = decoder_pkg::UART_TIMEOUT,
    parameter int unsigned VGA_BASE_ADDRESS = decoder_pkg::RGB_BASE_ADDRESS
) (
    input  logic                      CLOCK_50_I,
    input  logic                      resetn,
    input  logic                      UART_RX_I,
    output logic                      uart_rx_enable,
    input  logic                      uart_byte_received,
    input  logic [SRAM_AW-1:0]        uart_sram_address,
    input  logic [SRAM_DW-1:0]        uart_sram_write_data,
    input  logic                      uart_sram_we_n,
    output logic                      m2_start,
    input  logic                      m2_done,
    input  logic [SRAM_AW-1:0]        m2_sram_address,
    input  logic [SRAM_DW-1:0]        m2_sram_write_data,
    input  logic                      m2_sram_we_n,
    output logic                      m1_start,
    input  logic                      m1_done,
    input  logic [SRAM_AW-1:0]        m1_sram_address,
    input  logic [SRAM_DW-1:0]        m1_sram_write_data,
    input  logic                      m1_sram_we_n,
    input  logic [SRAM_AW-1:0]        vga_sram_address,
    decoder_top_sequencer_if.master   sram_bus,
    output top_state_t                top_state,
    output logic [UART_TIMER_W-1:0]   UART_timer,
    output logic [SRAM_AW-1:0]        VGA_base_address
);

    localparam logic [UART_TIMER_W-1:0] TIMEOUT_CNT = UART_TIMER_W'(UART_TIMEOUT_P);

    top_state_t              state_nxt;
    logic [UART_TIMER_W-1:0] timer_nxt;
    logic                    m2_start_nxt;
    logic                    m1_start_nxt;

    // rx_meta/rx_sync form the synchronizer; rx_sync_d is the previous synced
    // value used for edge detection
    logic rx_meta;
    logic rx_sync;
    logic rx_sync_d;
    logic rx_fall;

    logic [SRAM_AW-1:0] mux_address;
    logic [SRAM_DW-1:0] mux_write_data;
    logic               mux_we_n;

    assign rx_fall          = rx_sync_d & ~rx_sync;
    assign uart_rx_enable   = (top_state == S_ENABLE_UART_RX) || (top_state == S_WAIT_UART_RX);
    assign VGA_base_address = SRAM_AW'(VGA_BASE_ADDRESS);

    always_ff @(posedge CLOCK_50_I) begin
        if (!resetn) begin
            top_state  <= S_IDLE;
            UART_timer <= '0;
            m2_start   <= 1'b0;
            m1_start   <= 1'b0;
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_sync_d  <= 1'b1;
        end else begin
            top_state  <= state_nxt;
            UART_timer <= timer_nxt;
            m2_start   <= m2_start_nxt;
            m1_start   <= m1_start_nxt;
            rx_meta    <= UART_RX_I;
            rx_sync    <= rx_meta;
            rx_sync_d  <= rx_sync;
        end
    end

    always_comb begin
        state_nxt    = top_state;
        timer_nxt    = UART_timer;
        m2_start_nxt = 1'b0;
        m1_start_nxt = 1'b0;
        unique case (top_state)
            S_IDLE: begin
                if (rx_fall) begin
                    state_nxt = S_ENABLE_UART_RX;
                end
            end
            S_ENABLE_UART_RX: begin
                timer_nxt = '0;
                state_nxt = S_WAIT_UART_RX;
            end
            S_WAIT_UART_RX: begin
                // a byte restarts the quiet period, even at terminal count
                if (uart_byte_received) begin
                    timer_nxt = '0;
                end else if (UART_timer == TIMEOUT_CNT) begin
                    timer_nxt    = '0;
                    m2_start_nxt = 1'b1;
                    state_nxt    = S_M2;
                end else begin
                    timer_nxt = UART_timer + 1'b1;
                end
            end
            S_M2: begin
                if (m2_done) begin
                    m1_start_nxt = 1'b1;
                    state_nxt    = S_M1;
                end
            end
            S_M1: begin
                if (m1_done) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    sram_port_mux u_sram_port_mux (
        .top_state            (top_state),
        .vga_sram_address     (vga_sram_address),
        .uart_sram_address    (uart_sram_address),
        .uart_sram_write_data (uart_sram_write_data),
        .uart_sram_we_n       (uart_sram_we_n),
        .m2_sram_address      (m2_sram_address),
        .m2_sram_write_data   (m2_sram_write_data),
        .m2_sram_we_n         (m2_sram_we_n),
        .m1_sram_address      (m1_sram_address),
        .m1_sram_write_data   (m1_sram_write_data),
        .m1_sram_we_n         (m1_sram_we_n),
        .sram_address         (mux_address),
        .sram_write_data      (mux_write_data),
        .sram_we_n            (mux_we_n)
    );

    assign sram_bus.SRAM_address    = mux_address;
    assign sram_bus.SRAM_write_data = mux_write_data;
    assign sram_bus.SRAM_we_n       = mux_we_n;

endmodule

// File: tb/tb_decoder_top_sequencer.sv
// ----------------------------------------------------------------------------
// tb_decoder_top_sequencer
// Directed sequence followed by a randomized phase, compared every cycle
// against a behavioural model of the sequencer. A short quiet-line timeout is
// used so the whole run stays a few thousand cycles long.
// ----------------------------------------------------------------------------
module tb_decoder_top_sequencer;
    import decoder_pkg::*;

    localparam int unsigned TO  = 20;
    localparam int unsigned VGA = 146944;

    logic        clk;
    logic        resetn;
    logic        UART_RX_I;
    logic        uart_rx_enable;
    logic        uart_byte_received;
    logic [19:0] uart_sram_address;
    logic [15:0] uart_sram_write_data;
    logic        uart_sram_we_n;
    logic        m2_start;
    logic        m2_done;
    logic [19:0] m2_sram_address;
    logic [15:0] m2_sram_write_data;
    logic        m2_sram_we_n;
    logic        m1_start;
    logic        m1_done;
    logic [19:0] m1_sram_address;
    logic [15:0] m1_sram_write_data;
    logic        m1_sram_we_n;
    logic [19:0] vga_sram_address;
    top_state_t  top_state;
    logic [25:0] UART_timer;
    logic [19:0] VGA_base_address;

    decoder_top_sequencer_if sram_bus ();

    decoder_top_sequencer #(
        .UART_TIMEOUT_P   (TO),
        .VGA_BASE_ADDRESS (VGA)
    ) dut (
        .CLOCK_50_I           (clk),
        .resetn               (resetn),
        .UART_RX_I            (UART_RX_I),
        .uart_rx_enable       (uart_rx_enable),
        .uart_byte_received   (uart_byte_received),
        .uart_sram_address    (uart_sram_address),
        .uart_sram_write_data (uart_sram_write_data),
        .uart_sram_we_n       (uart_sram_we_n),
        .m2_start             (m2_start),
        .m2_done              (m2_done),
        .m2_sram_address      (m2_sram_address),
        .m2_sram_write_data   (m2_sram_write_data),
        .m2_sram_we_n         (m2_sram_we_n),
        .m1_start             (m1_start),
        .m1_done              (m1_done),
        .m1_sram_address      (m1_sram_address),
        .m1_sram_write_data   (m1_sram_write_data),
        .m1_sram_we_n         (m1_sram_we_n),
        .vga_sram_address     (vga_sram_address),
        .sram_bus             (sram_bus),
        .top_state            (top_state),
        .UART_timer           (UART_timer),
        .VGA_base_address     (VGA_base_address)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit hold_bus = 1'b0;

    // model: phase 0 idle, 1 enabling, 2 waiting for quiet, 3 in M2, 4 in M1
    int          m_st;
    int unsigned m_timer;
    bit          m_m1s;
    bit          m_m2s;
    bit          rx_hist[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit fell;
        if (!resetn) begin
            m_st = 0; m_timer = 0; m_m1s = 0; m_m2s = 0;
            rx_hist = '{1'b1, 1'b1, 1'b1};
            return;
        end
        // the line is seen two cycles late; a fall is a 1 followed by a 0
        fell  = rx_hist[rx_hist.size()-3] && !rx_hist[rx_hist.size()-2];
        m_m1s = 0;
        m_m2s = 0;
        case (m_st)
            0: if (fell) m_st = 1;
            1: begin m_timer = 0; m_st = 2; end
            2: begin
                if (uart_byte_received) m_timer = 0;
                else if (m_timer == TO) begin m_timer = 0; m_st = 3; m_m2s = 1; end
                else m_timer = m_timer + 1;
            end
            3: if (m2_done) begin m_st = 4; m_m1s = 1; end
            4: if (m1_done) m_st = 0;
            default: m_st = 0;
        endcase
        rx_hist.push_back(UART_RX_I);
        if (rx_hist.size() > 6) void'(rx_hist.pop_front());
    endtask

    task automatic check_all();
        chk("top_state", 32'(top_state), 32'(m_st));
        chk("UART_timer", 32'(UART_timer), m_timer);
        chk("uart_rx_enable", 32'(uart_rx_enable), 32'(m_st == 1 || m_st == 2));
        chk("m2_start", 32'(m2_start), 32'(m_m2s));
        chk("m1_start", 32'(m1_start), 32'(m_m1s));
        chk("VGA_base_address", 32'(VGA_base_address), VGA);
        case (m_st)
            0: begin
                chk("idle addr", 32'(sram_bus.SRAM_address), 32'(vga_sram_address));
                chk("idle we_n", 32'(sram_bus.SRAM_we_n), 32'd1);
            end
            2: begin
                chk("uart addr", 32'(sram_bus.SRAM_address), 32'(uart_sram_address));
                chk("uart data", 32'(sram_bus.SRAM_write_data), 32'(uart_sram_write_data));
                chk("uart we_n", 32'(sram_bus.SRAM_we_n), 32'(uart_sram_we_n));
            end
            3: begin
                chk("m2 addr", 32'(sram_bus.SRAM_address), 32'(m2_sram_address));
                chk("m2 data", 32'(sram_bus.SRAM_write_data), 32'(m2_sram_write_data));
                chk("m2 we_n", 32'(sram_bus.SRAM_we_n), 32'(m2_sram_we_n));
            end
            4: begin
                chk("m1 addr", 32'(sram_bus.SRAM_address), 32'(m1_sram_address));
                chk("m1 data", 32'(sram_bus.SRAM_write_data), 32'(m1_sram_write_data));
                chk("m1 we_n", 32'(sram_bus.SRAM_we_n), 32'(m1_sram_we_n));
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        if (!hold_bus) begin
            vga_sram_address     = 20'($urandom);
            uart_sram_address    = 20'($urandom);
            uart_sram_write_data = 16'($urandom);
            uart_sram_we_n       = 1'($urandom);
            m2_sram_address      = 20'($urandom);
            m2_sram_write_data   = 16'($urandom);
            m2_sram_we_n         = 1'($urandom);
            m1_sram_address      = 20'($urandom);
            m1_sram_write_data   = 16'($urandom);
            m1_sram_we_n         = 1'($urandom);
        end
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic run_until_state(input top_state_t st, input int budget, input string tag);
        int n = 0;
        while (m_st != int'(st) && n < budget) begin tick(); n++; end
        chk(tag, 32'(top_state), 32'(st));
    endtask

    task automatic run_until_timer(input int unsigned v, input int budget, input string tag);
        int n = 0;
        while (!(m_st == 2 && m_timer == v) && n < budget) begin tick(); n++; end
        chk(tag, 32'(UART_timer), v);
    endtask

    task automatic uart_fall(input int low_cycles);
        UART_RX_I = 1'b0;
        repeat (low_cycles) tick();
        UART_RX_I = 1'b1;
    endtask

    initial begin
        resetn = 1'b0; UART_RX_I = 1'b1; uart_byte_received = 1'b0;
        m1_done = 1'b0; m2_done = 1'b0;
        vga_sram_address = '0; uart_sram_address = '0; uart_sram_write_data = '0;
        uart_sram_we_n = 1'b1; m2_sram_address = '0; m2_sram_write_data = '0;
        m2_sram_we_n = 1'b1; m1_sram_address = '0; m1_sram_write_data = '0;
        m1_sram_we_n = 1'b1;
        rx_hist = '{1'b1, 1'b1, 1'b1};
        m_st = 0; m_timer = 0; m_m1s = 0; m_m2s = 0;
        #3;

        // reset held three cycles
        repeat (3) tick();
        chk("reset top_state", 32'(top_state), 32'(S_IDLE));
        chk("reset we_n", 32'(sram_bus.SRAM_we_n), 32'd1);
        chk("reset timer", 32'(UART_timer), 32'd0);
        chk("reset starts", {30'd0, m1_start, m2_start}, 32'd0);
        resetn = 1'b1;
        tick();

        // done pulses ignored while idle
        m1_done = 1'b1; m2_done = 1'b1; tick(); m1_done = 1'b0; m2_done = 1'b0;
        tick();
        chk("idle ignores done", 32'(top_state), 32'(S_IDLE));

        // UART line falls for 5 cycles
        uart_fall(5);
        run_until_state(S_WAIT_UART_RX, 20, "reach wait");
        chk("rx_enable in wait", 32'(uart_rx_enable), 32'd1);

        // done pulse ignored while waiting
        m2_done = 1'b1; tick(); m2_done = 1'b0;
        chk("wait ignores done", 32'(top_state), 32'(S_WAIT_UART_RX));

        // byte one cycle before terminal count restarts the timer
        run_until_timer(TO - 1, 100, "timer at TO-1");
        uart_byte_received = 1'b1; tick(); uart_byte_received = 1'b0;
        chk("byte at TO-1 timer", 32'(UART_timer), 32'd0);
        chk("byte at TO-1 state", 32'(top_state), 32'(S_WAIT_UART_RX));

        // byte on the terminal count cycle wins over the timeout
        run_until_timer(TO, 100, "timer at TO");
        uart_byte_received = 1'b1; tick(); uart_byte_received = 1'b0;
        chk("byte at TO timer", 32'(UART_timer), 32'd0);
        chk("byte at TO state", 32'(top_state), 32'(S_WAIT_UART_RX));
        chk("byte at TO no start", 32'(m2_start), 32'd0);

        // quiet line times out into M2
        run_until_state(S_M2, 100, "reach M2");
        chk("m2_start pulse", 32'(m2_start), 32'd1);
        chk("rx_enable dropped", 32'(uart_rx_enable), 32'd0);
        tick();
        chk("m2_start one cycle", 32'(m2_start), 32'd0);

        // line activity outside idle is ignored
        uart_fall(4);
        repeat (4) tick();
        chk("M2 ignores rx fall", 32'(top_state), 32'(S_M2));

        // M2 drives the SRAM pins in the same cycle
        hold_bus = 1'b1;
        m2_sram_address = 20'd5; m2_sram_write_data = 16'hABCD; m2_sram_we_n = 1'b0;
        tick();
        chk("M2 pin addr", 32'(sram_bus.SRAM_address), 32'd5);
        chk("M2 pin data", 32'(sram_bus.SRAM_write_data), 32'hABCD);
        chk("M2 pin we_n", 32'(sram_bus.SRAM_we_n), 32'd0);
        hold_bus = 1'b0;

        m2_done = 1'b1; tick(); m2_done = 1'b0;
        chk("M1 entered", 32'(top_state), 32'(S_M1));
        chk("m1_start pulse", 32'(m1_start), 32'd1);
        tick();
        chk("m1_start one cycle", 32'(m1_start), 32'd0);

        m1_done = 1'b1; tick(); m1_done = 1'b0;
        chk("back to idle", 32'(top_state), 32'(S_IDLE));
        hold_bus = 1'b1; vga_sram_address = 20'd777;
        tick();
        chk("VGA pin addr", 32'(sram_bus.SRAM_address), 32'd777);
        chk("VGA pin we_n", 32'(sram_bus.SRAM_we_n), 32'd1);
        chk("VGA base", 32'(VGA_base_address), 32'd146944);
        hold_bus = 1'b0;

        // done on the first cycle of M2 is honoured
        uart_fall(3);
        run_until_state(S_M2, 100, "reach M2 again");
        m2_done = 1'b1; tick(); m2_done = 1'b0;
        chk("done on entry", 32'(top_state), 32'(S_M1));
        m1_done = 1'b1; tick(); m1_done = 1'b0;

        // reset during M2
        uart_fall(2);
        run_until_state(S_M2, 100, "reach M2 for reset");
        tick();
        resetn = 1'b0; m2_done = 1'b1; tick(); resetn = 1'b1; m2_done = 1'b0;
        chk("reset in M2 state", 32'(top_state), 32'(S_IDLE));
        chk("reset in M2 starts", {30'd0, m1_start, m2_start}, 32'd0);

        // reset during a partial UART load
        uart_fall(2);
        run_until_state(S_WAIT_UART_RX, 20, "reach wait for reset");
        repeat (5) tick();
        resetn = 1'b0; tick(); resetn = 1'b1;
        chk("reset in wait state", 32'(top_state), 32'(S_IDLE));
        chk("reset in wait timer", 32'(UART_timer), 32'd0);
        tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            UART_RX_I          = ($urandom_range(0, 15) != 0);
            uart_byte_received = ($urandom_range(0, 31) == 0);
            m2_done            = ($urandom_range(0, 7) == 0);
            m1_done            = ($urandom_range(0, 7) == 0);
            resetn             = ($urandom_range(0, 499) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
